grf_wb_arbiter: RTL
===================

GRF_WB_ARBITER -- requirements
Module: grf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter RR, default 1, meaning round-robin arbitration when 1 and fixed priority (2 > 1 > 0) when 0.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 3, write-back requests: bit0 ALU, bit1 MEM load, bit2 JAL link.
REQ-005 The block SHALL have ports addr0, addr1, addr2, input, 5 each, destination register of each requester.
REQ-006 The block SHALL have ports data0, data1, data2, input, 32 each, write data of each requester.
REQ-007 The block SHALL have port wr_ready, input, 1, meaning the register file accepts the current output write this cycle.
REQ-008 The block SHALL have ports A1_adress and A2_adress, input, 5 each, the decode-stage read addresses.
REQ-009 The block SHALL have port gnt, output, 3, a one-hot (or zero) combinational grant.
REQ-010 The block SHALL have ports RegWrite (output, 1), WD_adress (output, 5) and WD (output, 32), the registered register-file write port.
REQ-011 The block SHALL have port stall, output, 1, the combinational read-after-write hazard flag.
REQ-012 The block SHALL have port wb_count, output, 16, a count of committed writes.

Function
REQ-013 Handshake: a transfer from requester i SHALL occur on a rising edge where req[i] and gnt[i] are both 1.
- Requester holds req/addr/data stable until granted.
REQ-014 gnt SHALL be all zero when reset is 0, or when the output stage is valid and wr_ready is 0.
REQ-015 At most one gnt bit SHALL be 1 per cycle, and only for a requesting index.
REQ-016 With RR=1, the search SHALL start at (ptr+1) mod 3, where ptr is the last transferred index.
- ptr updates only on a transfer; reset value 2, so index 0 has first priority.
REQ-017 With RR=0, the highest requesting index SHALL win and ptr SHALL be unused.
REQ-018 Output stage is one entry (valid, addr, data). RegWrite SHALL equal valid AND (WD_adress != 0).
REQ-019 On a transfer with addr != 0, the output stage SHALL load addr/data on that edge.
- RegWrite = 1 the following cycle; latency is 1 cycle; throughput is 1 write per cycle.
REQ-020 A transfer with addr == 0 SHALL be consumed (gnt given, requester released) but SHALL not set valid and SHALL not count.
REQ-021 Output stage SHALL retire on an edge where valid and wr_ready are both 1.
- A new transfer on the same edge SHALL reload it (back-to-back, no bubble).
REQ-022 With valid = 1 and wr_ready = 0, the output stage SHALL hold WD_adress/WD unchanged and no grant SHALL issue.
REQ-023 wb_count SHALL increment by 1 on each retire, wrapping from 0xFFFF to 0x0000.
REQ-024 stall SHALL be 1 iff a nonzero A1_adress or A2_adress equals a pending write.
- Pending write: WD_adress while valid, or addr_i while req[i] = 1.
- Address 0 never stalls.
REQ-025 Two requesters targeting the same register SHALL both be written, in arbitration order; the later value remains.
REQ-026 Request withdrawal without a grant is illegal; behaviour is undefined and is checked by an assertion in the bench.

Reset
REQ-027 reset = 0 SHALL immediately and asynchronously clear valid, RegWrite, WD_adress, WD, wb_count and gnt, and set ptr to 2.
REQ-028 Reset asserted mid-operation SHALL discard a held output write, with no partial retire; operation resumes on the first edge after reset = 1.

Verification
REQ-029 Fixed points: after reset release, req=3'b111, all addr=5, data0=0x11, data1=0x22, data2=0x33, wr_ready=1, RR=1.
- Required: gnt 001, 010, 100 on consecutive cycles.
- Required: WD 0x11, 0x22, 0x33 one cycle later each.
- Required: wb_count ends at 3.
REQ-030 Backpressure: req0 with addr0=7, data0=0xA5, and wr_ready=0 for 3 cycles.
- Required: RegWrite=1, WD_adress=7, WD=0xA5 held for 3 cycles.
- Required: gnt=0 while blocked; one retire once wr_ready=1.
REQ-031 Zero register: req1 with addr1=0.
- Required: gnt=010 for one cycle and RegWrite stays 0.
- Required: wb_count unchanged and stall=0 with A1_adress=0.
REQ-032 Hazard: req2 pending with addr2=31 and A2_adress=31 -> stall=1.
- After the write retires with no other pending write to 31 -> stall=0.
REQ-033 Fixed priority: RR=0, req=3'b011 held for 2 cycles -> gnt=010 twice, then gnt=001 once req1 drops.
REQ-034 Reset mid-run: assert reset with valid=1 and wr_ready=0.
- Required: RegWrite=0 immediately, before the next clk edge, and wb_count=0.
- Required: after release, the first grant goes to index 0.

Source files
------------

// File: rtl/grf_wb_arbiter.sv
// Three-way write-back arbiter feeding a one-entry register-file write stage.
// Round-robin or fixed priority grant, back-to-back retire/reload, RAW hazard flag.
module grf_wb_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [4:0]  addr0,
  input  logic [4:0]  addr1,
  input  logic [4:0]  addr2,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic        wr_ready,
  input  logic [4:0]  A1_adress,
  input  logic [4:0]  A2_adress,
  output logic [2:0]  gnt,
  output logic        RegWrite,
  output logic [4:0]  WD_adress,
  output logic [31:0] WD,
  output logic        stall,
  output logic [15:0] wb_count
);
  localparam int NREQ = 3;

  logic [NREQ-1:0][4:0]  addr_v;
  logic [NREQ-1:0][31:0] data_v;
  assign addr_v = {addr2, addr1, addr0};
  assign data_v = {data2, data1, data0};

  logic        valid_q, valid_d;
  logic [4:0]  wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  ptr_q, ptr_d;

  logic        blocked, xfer, retire;
  logic [1:0]  sel_idx;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  assign blocked = valid_q && !wr_ready;
  assign retire  = valid_q && wr_ready;

  // Round-robin search starts just after the last transferred index.
  always_comb begin
    gnt = '0;
    if (reset && !blocked) begin
      if (RR) begin
        unique case (ptr_q)
          2'd0: begin
            if      (req[1]) gnt = 3'b010;
            else if (req[2]) gnt = 3'b100;
            else if (req[0]) gnt = 3'b001;
          end
          2'd1: begin
            if      (req[2]) gnt = 3'b100;
            else if (req[0]) gnt = 3'b001;
            else if (req[1]) gnt = 3'b010;
          end
          default: begin
            if      (req[0]) gnt = 3'b001;
            else if (req[1]) gnt = 3'b010;
            else if (req[2]) gnt = 3'b100;
          end
        endcase
      end else begin
        if      (req[2]) gnt = 3'b100;
        else if (req[1]) gnt = 3'b010;
        else if (req[0]) gnt = 3'b001;
      end
    end
  end

  assign xfer    = |(req & gnt);
  assign sel_idx = gnt[2] ? 2'd2 : (gnt[1] ? 2'd1 : 2'd0);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = addr_v[i];
        sel_data = data_v[i];
      end
    end
  end

  // A zero-destination transfer is consumed but never occupies the stage.
  always_comb begin
    valid_d = valid_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (xfer && sel_addr != 5'd0) begin
      valid_d = 1'b1;
      wa_d    = sel_addr;
      wd_d    = sel_data;
    end else if (retire) begin
      valid_d = 1'b0;
    end
    if (retire) cnt_d = cnt_q + 16'd1;
    if (xfer)   ptr_d = sel_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      ptr_q   <= 2'd2;
    end else begin
      valid_q <= valid_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  logic [NREQ-1:0] m1, m2;
  for (genvar i = 0; i < NREQ; i++) begin : g_haz
    assign m1[i] = req[i] && (addr_v[i] == A1_adress);
    assign m2[i] = req[i] && (addr_v[i] == A2_adress);
  end

  assign stall = ((A1_adress != 5'd0) && ((|m1) || (valid_q && wa_q == A1_adress))) ||
                 ((A2_adress != 5'd0) && ((|m2) || (valid_q && wa_q == A2_adress)));

  assign RegWrite  = valid_q && (wa_q != 5'd0);
  assign WD_adress = wa_q;
  assign WD        = wd_q;
  assign wb_count  = cnt_q;
endmodule
